// File: rtl/pad6_seq.sv
// Mega Drive 6-button pad sequencer: tracks TH edges, expires the edge
// count after TH idles, and muxes the button nibble onto the port pins.
module pad6_seq #(
  parameter int TIMEOUT = 86000,
  parameter int TW      = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        six_btn,
  input  logic        th_in,
  input  logic [11:0] btn,
  output logic [5:0]  data_out,
  output logic [2:0]  phase,
  output logic        timeout_pulse
);

  localparam logic [TW-1:0] T_ARM = TW'(TIMEOUT - 2);

  logic          th_q;
  logic [TW-1:0] timer;
  logic          expired;
  logic [2:0]    k;

  logic          fall;
  logic          rise;
  logic          th_edge;
  logic          expire;
  logic [2:0]    k_base;
  logic [2:0]    k_nxt;
  logic [TW-1:0] timer_nxt;
  logic          exp_nxt;
  logic          pulse_nxt;
  logic [5:0]    data_nxt;

  logic [5:0]    hi_norm;
  logic [5:0]    hi_ext;
  logic [5:0]    lo_norm;
  logic [5:0]    lo_k3;
  logic [5:0]    lo_k4;

  // btn order: {MODE,X,Y,Z,START,C,B,A,RIGHT,LEFT,DOWN,UP}
  always_comb begin
    hi_norm = ~{btn[6], btn[5], btn[3:0]};
    hi_ext  = ~{btn[6], btn[5], btn[11], btn[10], btn[9], btn[8]};
    lo_norm = {~btn[7], ~btn[4], 2'b00, ~btn[1], ~btn[0]};
    lo_k3   = {~btn[7], ~btn[4], 4'b0000};
    lo_k4   = {~btn[7], ~btn[4], 4'b1111};
  end

  always_comb begin
    fall    = th_q & ~th_in;
    rise    = ~th_q & th_in;
    th_edge = fall | rise;
    expire  = ~expired & (timer == T_ARM);

    // an edge in the expiry cycle counts from the expired (zero) count
    k_base = expire ? 3'd0 : k;
    k_nxt  = k_base;
    if (fall && (k_base != 3'd7))
      k_nxt = k_base + 3'd1;

    timer_nxt = timer;
    exp_nxt   = expired;
    pulse_nxt = 1'b0;
    if (th_edge) begin
      timer_nxt = '0;
      exp_nxt   = 1'b0;
    end else if (expire) begin
      timer_nxt = timer + 1'b1;
      exp_nxt   = 1'b1;
      pulse_nxt = 1'b1;
    end else if (!expired) begin
      timer_nxt = timer + 1'b1;
    end
  end

  always_comb begin
    data_nxt = lo_norm;
    unique case (1'b1)
      (th_in && six_btn && k_nxt == 3'd3):   data_nxt = hi_ext;
      (th_in && !(six_btn && k_nxt == 3'd3)): data_nxt = hi_norm;
      (!th_in && six_btn && k_nxt == 3'd3):  data_nxt = lo_k3;
      (!th_in && six_btn && k_nxt == 3'd4):  data_nxt = lo_k4;
      (!th_in && !(six_btn && (k_nxt == 3'd3 || k_nxt == 3'd4))):
        data_nxt = lo_norm;
      default: data_nxt = lo_norm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q          <= 1'b1;
      timer         <= '0;
      expired       <= 1'b0;
      k             <= 3'd0;
      timeout_pulse <= 1'b0;
      data_out      <= 6'h3F;
    end else begin
      th_q          <= th_in;
      timer         <= timer_nxt;
      expired       <= exp_nxt;
      k             <= k_nxt;
      timeout_pulse <= pulse_nxt;
      data_out      <= data_nxt;
    end
  end

  assign phase = k;

endmodule

// File: tb/tb_pad6_seq.sv
// Scoreboard bench for pad6_seq: stimulus queues expected port values,
// a monitor pops and compares them each cycle.
module tb_pad6_seq;

  localparam int T = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        six_btn = 1'b0;
  logic        th_in = 1'b1;
  logic [11:0] btn = '0;
  logic [5:0]  data_out;
  logic [2:0]  phase;
  logic        timeout_pulse;

  pad6_seq #(.TIMEOUT(T), .TW(6)) dut (
    .clk(clk),
    .reset(reset),
    .six_btn(six_btn),
    .th_in(th_in),
    .btn(btn),
    .data_out(data_out),
    .phase(phase),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] d;
    logic [2:0] ph;
    logic       tp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || data_out !== e.d || phase !== e.ph ||
            timeout_pulse !== e.tp) begin
          errors++;
          $display("FAIL chk cyc=%0d due=%0d data got %h exp %h phase got %0d exp %0d pulse got %b exp %b",
                   cyc, e.cyc, data_out, e.d, phase, e.ph, timeout_pulse, e.tp);
        end
      end
    end
  end

  task automatic push(input logic [5:0] d, input logic [2:0] ph,
                      input logic tp);
    exp_t e;
    e.cyc = cyc + 1;
    e.d   = d;
    e.ph  = ph;
    e.tp  = tp;
    q.push_back(e);
  endtask

  task automatic step(input logic th, input logic [5:0] d,
                      input logic [2:0] ph, input logic tp);
    th_in = th;
    push(d, ph, tp);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic th);
    reset = 1'b1;
    th_in = th;
    push(6'h3F, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic steps(input int n, input logic th, input logic [5:0] d,
                       input logic [2:0] ph);
    for (int i = 0; i < n; i++)
      step(th, d, ph, 1'b0);
  endtask

  // three falls ending low at k=3 with six_btn set
  task automatic to_k3(input int n);
    steps(n, 1'b0, 6'h13, 3'd1);
    steps(n, 1'b1, 6'h3F, 3'd1);
    steps(n, 1'b0, 6'h13, 3'd2);
    steps(n, 1'b1, 6'h3F, 3'd2);
    steps(n, 1'b0, 6'h10, 3'd3);
  endtask

  logic [5:0] ex6 [9] = '{6'h3F, 6'h13, 6'h3F, 6'h13, 6'h3F,
                          6'h10, 6'h3B, 6'h1F, 6'h3F};
  logic [5:0] ex3 [9] = '{6'h3F, 6'h13, 6'h3F, 6'h13, 6'h3F,
                          6'h13, 6'h3F, 6'h13, 6'h3F};
  logic [2:0] ek  [9] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2,
                          3'd3, 3'd3, 3'd4, 3'd4};

  initial begin
    repeat (2) @(negedge clk);

    // reset state, then a lone button change
    six_btn = 1'b0;
    btn = 12'h000;
    do_reset(1'b1);
    steps(2, 1'b1, 6'h3F, 3'd0);
    btn = 12'h001;
    steps(2, 1'b1, 6'h3E, 3'd0);

    // 6-button sequence with START and X held
    six_btn = 1'b1;
    btn = 12'h480;
    do_reset(1'b1);
    for (int h = 0; h < 9; h++)
      steps(10, (h % 2 == 0), ex6[h], ek[h]);

    // same sequence as a 3-button pad
    six_btn = 1'b0;
    do_reset(1'b1);
    for (int h = 0; h < 9; h++)
      steps(10, (h % 2 == 0), ex3[h], ek[h]);

    // idle expiry after three falls
    six_btn = 1'b1;
    do_reset(1'b1);
    to_k3(4);
    for (int j = 0; j < T + 4; j++)
      step(1'b1, (j < T - 1) ? 6'h3B : 6'h3F,
           (j < T - 1) ? 3'd3 : 3'd0, (j == T - 1));
    steps(3, 1'b0, 6'h13, 3'd1);

    // fall landing in the expiry cycle
    do_reset(1'b1);
    to_k3(4);
    for (int j = 0; j < T - 1; j++)
      step(1'b1, 6'h3B, 3'd3, 1'b0);
    steps(4, 1'b0, 6'h13, 3'd1);

    // reset mid-sequence at k=3 with TH low
    do_reset(1'b1);
    to_k3(3);
    do_reset(1'b0);
    steps(2, 1'b0, 6'h13, 3'd1);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d entries, need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
